// File: rtl/slant_read_scheduler.sv
// Raster scheduler for the HDMI read side of the slanted 4-bank frame buffer; runs entirely in the Hclk domain.
// Optional build macro SLANT_TEST_PATTERN_EN replaces the overlay colour with eight VDE-aligned vertical colour bars.
module slant_read_scheduler #(
    parameter int H_ACTIVE  = 640,
    parameter int H_FP      = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BP      = 48,
    parameter int V_ACTIVE  = 480,
    parameter int V_FP      = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BP      = 33,
    parameter int READ_LEAD = 4
) (
    input  logic        Hclk,
    input  logic        rstn,
    input  logic        en,
    input  logic        FraimSync,
    input  logic [3:0]  cfg_bank_mask,
    input  logic        cfg_sel,
    input  logic [23:0] cfg_rgb,
    output logic        HVsync,
    output logic        HMemRead,
    output logic        pVDE,
    output logic        VDE,
    output logic        HSync,
    output logic        VSync,
    output logic [3:0]  Mem_cont,
    output logic        Sel,
    output logic [23:0] Sel_RGB,
    output logic [7:0]  frame_cnt,
    output logic        busy
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW      = $clog2(H_TOTAL);
    localparam int VW      = $clog2(V_TOTAL);

    localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] H_ACT  = HW'(H_ACTIVE);
    localparam logic [HW-1:0] HS_BEG = HW'(H_ACTIVE + H_FP);
    localparam logic [HW-1:0] HS_END = HW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] V_ACT  = VW'(V_ACTIVE);
    localparam logic [VW-1:0] VS_BEG = VW'(V_ACTIVE + V_FP);
    localparam logic [VW-1:0] VS_END = VW'(V_ACTIVE + V_FP + V_SYNC);

    typedef enum logic [1:0] {IDLE = 2'd0, WAIT_FS = 2'd1, RUN = 2'd2} state_t;

    state_t          state_r, state_n;
    logic [HW-1:0]   h_cnt_r, h_n;
    logic [VW-1:0]   v_cnt_r, v_n;
    logic            fs_meta_r, fs_sync_r, fs_prev_r;
    logic            fs_edge_s, load_s, frame_end_s, run_s;
    logic            active_s, hs_low_s, vs_low_s, hvs_n_s;
    logic            hs0_r, vs0_r;
    logic            rd_sr [READ_LEAD];
    logic            hs_sr [READ_LEAD+1];
    logic            vs_sr [READ_LEAD+1];

    assign pVDE  = rd_sr[READ_LEAD-1];
    assign HSync = hs_sr[READ_LEAD];
    assign VSync = vs_sr[READ_LEAD];

    // Next-state, counter advance and frame-boundary decode
    always_comb begin
        state_n     = state_r;
        h_n         = '0;
        v_n         = '0;
        load_s      = 1'b0;
        frame_end_s = 1'b0;
        fs_edge_s   = fs_sync_r ^ fs_prev_r;
        run_s       = (state_r == RUN);
        case (state_r)
            IDLE: begin
                if (en) state_n = WAIT_FS;
                else    state_n = IDLE;
            end
            WAIT_FS: begin
                if (!en) begin
                    state_n = IDLE;
                end else if (fs_edge_s) begin
                    state_n = RUN;
                    load_s  = 1'b1;
                end else begin
                    state_n = WAIT_FS;
                end
            end
            RUN: begin
                frame_end_s = (h_cnt_r == H_LAST) && (v_cnt_r == V_LAST);
                if (h_cnt_r == H_LAST) begin
                    h_n = '0;
                    if (v_cnt_r == V_LAST) v_n = '0;
                    else                   v_n = v_cnt_r + 1'b1;
                end else begin
                    h_n = h_cnt_r + 1'b1;
                    v_n = v_cnt_r;
                end
                if (frame_end_s) begin
                    load_s = 1'b1;
                    if (en) state_n = RUN;
                    else    state_n = IDLE;
                end else begin
                    state_n = RUN;
                end
            end
            default: state_n = IDLE;
        endcase
        active_s = run_s && (v_cnt_r < V_ACT) && (h_cnt_r < H_ACT);
        hs_low_s = run_s && (h_cnt_r >= HS_BEG) && (h_cnt_r < HS_END);
        vs_low_s = run_s && (v_cnt_r >= VS_BEG) && (v_cnt_r < VS_END);
        hvs_n_s  = (state_n == RUN) && (v_n < V_ACT);
    end

`ifdef SLANT_TEST_PATTERN_EN
    logic [HW-1:0] col0_r;
    logic [HW-1:0] col_sr [READ_LEAD];

    function automatic logic [23:0] bar_colour(input logic [HW-1:0] col);
        logic [23:0] c;
        if (col >= H_ACT) begin
            c = 24'h000000;
        end else begin
            case (3'(col / HW'(H_ACTIVE / 8)))
                3'd0:    c = 24'hFFFFFF;
                3'd1:    c = 24'hFFFF00;
                3'd2:    c = 24'h00FFFF;
                3'd3:    c = 24'h00FF00;
                3'd4:    c = 24'hFF00FF;
                3'd5:    c = 24'hFF0000;
                3'd6:    c = 24'h0000FF;
                default: c = 24'h000000;
            endcase
        end
        return c;
    endfunction

    // Column pipeline so the bar colour lands on the same cycle as VDE
    always_ff @(posedge Hclk or negedge rstn) begin
        if (!rstn) begin
            col0_r  <= '0;
            Sel_RGB <= 24'h000000;
            for (int i = 0; i < READ_LEAD; i++) col_sr[i] <= '0;
        end else begin
            col0_r    <= h_cnt_r;
            col_sr[0] <= col0_r;
            for (int i = 1; i < READ_LEAD; i++) col_sr[i] <= col_sr[i-1];
            Sel_RGB <= bar_colour(col_sr[READ_LEAD-1]);
        end
    end
`else
    // Overlay colour is shadowed with the rest of the configuration
    always_ff @(posedge Hclk or negedge rstn) begin
        if (!rstn) Sel_RGB <= 24'h000000;
        else if (load_s) Sel_RGB <= cfg_rgb;
    end
`endif

    // FSM, raster counters, strobes, delay lines and shadow configuration
    always_ff @(posedge Hclk or negedge rstn) begin
        if (!rstn) begin
            state_r   <= IDLE;
            h_cnt_r   <= '0;
            v_cnt_r   <= '0;
            fs_meta_r <= 1'b0;
            fs_sync_r <= 1'b0;
            fs_prev_r <= 1'b0;
            busy      <= 1'b0;
            HVsync    <= 1'b0;
            HMemRead  <= 1'b0;
            VDE       <= 1'b0;
            hs0_r     <= 1'b1;
            vs0_r     <= 1'b1;
            Mem_cont  <= 4'hF;
            Sel       <= 1'b0;
            frame_cnt <= 8'd0;
            for (int i = 0; i < READ_LEAD; i++) rd_sr[i] <= 1'b0;
            for (int i = 0; i <= READ_LEAD; i++) begin
                hs_sr[i] <= 1'b1;
                vs_sr[i] <= 1'b1;
            end
        end else begin
            fs_meta_r <= FraimSync;
            fs_sync_r <= fs_meta_r;
            fs_prev_r <= fs_sync_r;
            state_r   <= state_n;
            h_cnt_r   <= h_n;
            v_cnt_r   <= v_n;
            busy      <= (state_n == RUN);
            HVsync    <= hvs_n_s;
            HMemRead  <= active_s;
            hs0_r     <= ~hs_low_s;
            vs0_r     <= ~vs_low_s;
            // Delay lines keep shifting outside RUN so in-flight pixels drain
            rd_sr[0]  <= HMemRead;
            hs_sr[0]  <= hs0_r;
            vs_sr[0]  <= vs0_r;
            for (int i = 1; i < READ_LEAD; i++) rd_sr[i] <= rd_sr[i-1];
            for (int i = 1; i <= READ_LEAD; i++) begin
                hs_sr[i] <= hs_sr[i-1];
                vs_sr[i] <= vs_sr[i-1];
            end
            VDE <= rd_sr[READ_LEAD-1];
            if (load_s) begin
                Mem_cont <= cfg_bank_mask;
                Sel      <= cfg_sel;
            end
            if (frame_end_s) frame_cnt <= frame_cnt + 8'd1;
        end
    end
endmodule
